// File: rtl/mem_arbiter.sv
// Two-client (AES/SHA) burst arbiter for one shared memory port.
// Define MEM_ARB_RR_EN for round-robin arbitration; otherwise AES has fixed priority.
module mem_arbiter #(
    parameter int ADDRW = 24,
    parameter int LENW  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_aes,
    input  logic [ADDRW-1:0] addr_aes,
    input  logic [LENW-1:0]  len_aes,
    input  logic             wr_aes,
    output logic             gnt_aes,
    output logic             done_aes,
    input  logic             req_sha,
    input  logic [ADDRW-1:0] addr_sha,
    input  logic [LENW-1:0]  len_sha,
    input  logic             wr_sha,
    output logic             gnt_sha,
    output logic             done_sha,
    output logic             bus_valid,
    input  logic             bus_ready,
    output logic [ADDRW-1:0] bus_addr,
    output logic             bus_wr,
    output logic             bus_last,
    output logic             owner
);

    typedef enum logic [1:0] {
        IDLE,
        XFER,
        DONE
    } state_t;

    state_t          state;
    logic [LENW-1:0] len_q;
    logic [LENW-1:0] beat;
    logic [LENW-1:0] beat_inc;
    logic            winner_sha;

`ifdef MEM_ARB_RR_EN
    logic last_sha;

    // On contention the client not served last wins.
    always_comb begin
        winner_sha = req_sha && (!req_aes || !last_sha);
    end
`else
    always_comb begin
        winner_sha = req_sha && !req_aes;
    end
`endif

    always_comb begin
        beat_inc = beat + LENW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            gnt_aes   <= 1'b0;
            gnt_sha   <= 1'b0;
            done_aes  <= 1'b0;
            done_sha  <= 1'b0;
            bus_valid <= 1'b0;
            bus_last  <= 1'b0;
            bus_wr    <= 1'b0;
            bus_addr  <= '0;
            owner     <= 1'b0;
            beat      <= '0;
            len_q     <= '0;
`ifdef MEM_ARB_RR_EN
            last_sha  <= 1'b1;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (req_aes || req_sha) begin
                        owner     <= winner_sha;
                        gnt_aes   <= !winner_sha;
                        gnt_sha   <= winner_sha;
                        bus_valid <= 1'b1;
                        bus_addr  <= winner_sha ? addr_sha : addr_aes;
                        bus_wr    <= winner_sha ? wr_sha : wr_aes;
                        len_q     <= winner_sha ? len_sha : len_aes;
                        bus_last  <= (winner_sha ? len_sha : len_aes) == '0;
                        beat      <= '0;
                        state     <= XFER;
                    end
                end
                XFER: begin
                    if (bus_ready) begin
                        if (bus_last) begin
                            gnt_aes   <= 1'b0;
                            gnt_sha   <= 1'b0;
                            bus_valid <= 1'b0;
                            bus_last  <= 1'b0;
                            done_aes  <= !owner;
                            done_sha  <= owner;
                            state     <= DONE;
                        end else begin
                            // Address register advances alongside the beat count, wrapping at 2^ADDRW.
                            beat     <= beat_inc;
                            bus_addr <= bus_addr + ADDRW'(1);
                            bus_last <= (beat_inc == len_q);
                        end
                    end
                end
                DONE: begin
                    done_aes <= 1'b0;
                    done_sha <= 1'b0;
`ifdef MEM_ARB_RR_EN
                    last_sha <= owner;
`endif
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The parameter ADDRW SHALL default to 24 and set the address width.
REQ-002 The parameter LENW SHALL default to 8 and set the burst-length field width.
REQ-003 clk  in  1  single clock; all logic on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 req_aes  in  1  AES core requests the shared memory port; held until done_aes.
REQ-006 addr_aes  in  ADDRW  AES burst base address.
REQ-007 len_aes  in  LENW  AES burst beats minus one (0 = 1 beat).
REQ-008 wr_aes  in  1  AES direction (1 = write, 0 = read).
REQ-009 gnt_aes  out  1  AES owns the port.
REQ-010 done_aes  out  1  one-cycle pulse: AES burst complete.
REQ-011 req_sha, addr_sha, len_sha, wr_sha, gnt_sha, done_sha SHALL mirror REQ-005..REQ-010 for the SHA core.
REQ-012 bus_valid  out  1  beat presented on the shared port.
REQ-013 bus_ready  in  1  memory accepts the beat.
REQ-014 bus_addr  out  ADDRW  beat address.
REQ-015 bus_wr  out  1  beat direction.
REQ-016 bus_last  out  1  final beat of the burst.
REQ-017 owner  out  1  0 = AES, 1 = SHA; valid while either gnt is high.

Function
REQ-018 The FSM SHALL have the states IDLE, XFER and DONE.
REQ-019 IDLE: if any req is high, pick the winner (REQ-027), latch its addr/len/wr, clear the beat counter, and go to XFER; otherwise stay in IDLE.
REQ-020 Latency: req sampled high in IDLE at edge n -> gnt_x and bus_valid high from edge n+1.
REQ-021 XFER: gnt_x=1, bus_valid=1, bus_addr=base+beat (modulo 2^ADDRW, wrapping silently), bus_wr=latched wr.
REQ-022 A beat SHALL transfer only when bus_valid && bus_ready; bus_addr, bus_wr and bus_last SHALL stay stable while bus_valid && !bus_ready.
REQ-023 bus_last SHALL equal (beat == latched len) during XFER; a transfer with bus_last high SHALL move the FSM to DONE.
REQ-024 DONE: gnt and bus_valid low, done_x high for exactly one cycle, arbitration pointer updated, then return to IDLE.
REQ-025 Input changes on addr/len/wr or deassertion of req during XFER SHALL be ignored; the latched burst runs to completion.
REQ-026 gnt_aes and gnt_sha SHALL never be high together; done_aes and done_sha SHALL never be high together.
REQ-027 Arbitration SHALL follow REQ-034/REQ-035; with a single requester, that requester always wins.
REQ-028 Back-to-back: the minimum gap from done_x to the next gnt is one IDLE cycle (3-cycle burst overhead: IDLE, XFER..., DONE).

Reset
REQ-029 On rst high at a clock edge: FSM -> IDLE; gnt_*, done_*, bus_valid, bus_last, bus_wr, owner = 0; bus_addr = 0; beat counter = 0.
REQ-030 The round-robin pointer SHALL reset to "last served = SHA" so AES wins the first contention.
REQ-031 Reset asserted mid-burst SHALL abort the burst with no done pulse; the outputs take the reset values at that edge.
REQ-032 rst SHALL dominate all other inputs in the same cycle.

Configuration
REQ-033 The macro MEM_ARB_RR_EN SHALL select the arbitration policy.
REQ-034 With MEM_ARB_RR_EN defined: when both req are high in IDLE, grant the requester not served last; the pointer updates in DONE.
REQ-035 Without MEM_ARB_RR_EN: fixed priority, AES over SHA; the pointer logic is absent.

Verification
REQ-036 Single beat: req_aes=1, addr_aes=0x000100, len_aes=0, wr_aes=1, bus_ready=1 -> gnt_aes next cycle; one beat at 0x000100 with bus_last=1; done_aes pulses one cycle later.
REQ-037 Burst with stalls: req_sha, addr=0x000010, len=3, bus_ready low on alternate cycles -> addresses 0x10,0x11,0x12,0x13 each held until accepted; bus_last only on 0x13; exactly 4 transfers.
REQ-038 Contention (RR build): req_aes and req_sha both held high, len=1 each -> grant order AES, SHA, AES, SHA; never both gnt high. Fixed-priority build -> AES repeatedly.
REQ-039 Wrap: addr_aes=0xFFFFFE, len=3 -> bus_addr 0xFFFFFE, 0xFFFFFF, 0x000000, 0x000001.
REQ-040 Mid-burst reset: len=7, rst high after 3 beats -> next cycle all outputs 0, no done pulse; a new req after rst falls gets a fresh grant with AES first.
